tachyon_regfile_mp: RTL and testbench

Parametrised multi-port register file for the Tachyon core. It supersedes the fixed 32x64, 3-read/1-write file. It adds configurable depth, width and port counts, a synchronous reset, write-to-read bypass, an optional hardwired zero register, and a per-register busy scoreboard used by issue logic to detect pending producers. It sits between decode/issue (read ports, scoreboard set) and writeback (write ports).

---
 rtl/tachyon_regfile_mp_if.sv | 50 +++++
 rtl/tachyon_regfile_mp.sv | 110 +++++++++++
 tb/tb_tachyon_regfile_mp.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/tachyon_regfile_mp_if.sv
// ---------------------------------------------------------------------------
// tachyon_regfile_mp_if
//
// Purpose: bundles the read, write and scoreboard signals of the Tachyon
// multi-port register file so that issue/writeback logic and the register
// file connect through one port.
//
// Parameters must match those of the tachyon_regfile_mp instance it binds to.
//
// Signals:
//   rd_addr[RD_PORTS]  read addresses            (master -> slave)
//   rd_val[RD_PORTS]   read data, combinational  (slave  -> master)
//   rd_busy[RD_PORTS]  busy bit of read address  (slave  -> master)
//   wr_enable[WR_PORTS], wr_addr[WR_PORTS], wr_val[WR_PORTS]
//                      write ports               (master -> slave)
//   sb_set_en, sb_set_addr
//                      mark a register busy      (master -> slave)
//   busy[SIZE]         registered scoreboard     (slave  -> master)
// ---------------------------------------------------------------------------
interface tachyon_regfile_mp_if #(
  parameter int SIZE      = 32,
  parameter int REG_WIDTH = 64,
  parameter int RD_PORTS  = 3,
  parameter int WR_PORTS  = 2
);
  localparam int ADDR_WIDTH = $clog2(SIZE);

  logic [ADDR_WIDTH-1:0] rd_addr   [RD_PORTS];
  logic [REG_WIDTH-1:0]  rd_val    [RD_PORTS];
  logic                  rd_busy   [RD_PORTS];

  logic                  wr_enable [WR_PORTS];
  logic [ADDR_WIDTH-1:0] wr_addr   [WR_PORTS];
  logic [REG_WIDTH-1:0]  wr_val    [WR_PORTS];

  logic                  sb_set_en;
  logic [ADDR_WIDTH-1:0] sb_set_addr;

  logic [SIZE-1:0]       busy;

  modport master (
    output rd_addr, wr_enable, wr_addr, wr_val, sb_set_en, sb_set_addr,
    input  rd_val, rd_busy, busy
  );

  modport slave (
    input  rd_addr, wr_enable, wr_addr, wr_val, sb_set_en, sb_set_addr,
    output rd_val, rd_busy, busy
  );
endinterface

// File: rtl/tachyon_regfile_mp.sv
// ---------------------------------------------------------------------------
// tachyon_regfile_mp
//
// Purpose: parametrised multi-port register file for the Tachyon core with
// write-to-read bypass, an optional hardwired zero register and a per-register
// busy scoreboard used by issue logic to detect pending producers.
//
// Ports:
//   clk  single clock, all state updates on posedge
//   rst  synchronous active-high reset; clears registers and busy bits
//   bus  tachyon_regfile_mp_if.slave carrying read ports, write ports,
//        scoreboard set request and the registered busy vector
//
// ADDR_WIDTH is derived from SIZE and is not a parameter.
// ---------------------------------------------------------------------------
module tachyon_regfile_mp #(
  parameter int SIZE      = 32,
  parameter int REG_WIDTH = 64,
  parameter int RD_PORTS  = 3,
  parameter int WR_PORTS  = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  tachyon_regfile_mp_if.slave   bus
);
  localparam int ADDR_WIDTH = $clog2(SIZE);

  logic [REG_WIDTH-1:0] regs      [SIZE];
  logic [SIZE-1:0]      busy_q;
  logic [SIZE-1:0]      busy_next;

  // Per-register write decode. wr_hit[r] means some enabled port targets r,
  // wr_data[r] is the value of the winning port.
  logic [SIZE-1:0]      wr_hit;
  logic [REG_WIDTH-1:0] wr_data   [SIZE];

  // Ports are scanned in ascending order so a later (higher-indexed) match
  // overwrites an earlier one, giving the highest index priority. Register 0
  // never sees a hit when it is hardwired, which also keeps bypass of address
  // 0 and the scoreboard clear of register 0 inert.
  always_comb begin
    for (int r = 0; r < SIZE; r++) begin
      wr_hit[r]  = 1'b0;
      wr_data[r] = '0;
      for (int p = 0; p < WR_PORTS; p++) begin
        if (bus.wr_enable[p] && (bus.wr_addr[p] == ADDR_WIDTH'(r))) begin
          wr_hit[r]  = 1'b1;
          wr_data[r] = bus.wr_val[p];
        end
      end
    end
    if (ZERO_REG != 0) begin
      wr_hit[0] = 1'b0;
    end
  end

  // Scoreboard next state: a new producer (set) wins over a retiring one
  // (writeback clear) targeting the same register in the same cycle.
  always_comb begin
    for (int r = 0; r < SIZE; r++) begin
      if (bus.sb_set_en && (bus.sb_set_addr == ADDR_WIDTH'(r))) begin
        busy_next[r] = 1'b1;
      end else if (wr_hit[r]) begin
        busy_next[r] = 1'b0;
      end else begin
        busy_next[r] = busy_q[r];
      end
    end
    if (ZERO_REG != 0) begin
      busy_next[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < SIZE; r++) begin
        regs[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < SIZE; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_data[r];
        end
      end
      busy_q <= busy_next;
    end
  end

  // Read ports are fully independent. Address 0 is forced to zero when
  // hardwired so that an un-reset storage slot can never leak through.
  // rd_busy deliberately uses the registered busy bit without bypass.
  always_comb begin
    for (int j = 0; j < RD_PORTS; j++) begin
      bus.rd_val[j] = regs[bus.rd_addr[j]];
      if ((BYPASS != 0) && wr_hit[bus.rd_addr[j]]) begin
        bus.rd_val[j] = wr_data[bus.rd_addr[j]];
      end
      if ((ZERO_REG != 0) && (bus.rd_addr[j] == '0)) begin
        bus.rd_val[j] = '0;
      end
      bus.rd_busy[j] = busy_q[bus.rd_addr[j]];
    end
  end

  assign bus.busy = busy_q;

endmodule

// File: tb/tb_tachyon_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_tachyon_regfile_mp
//
// Purpose: self-checking bench for tachyon_regfile_mp. Two instances share
// identical stimulus: dut_byp (BYPASS=1) and dut_nob (BYPASS=0), both with
// ZERO_REG=1. Expected values are hand-computed and queued when stimulus is
// issued; a monitor process drains the queue each cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_tachyon_regfile_mp;
  localparam int SIZE      = 32;
  localparam int REG_WIDTH = 64;
  localparam int RD_PORTS  = 3;
  localparam int WR_PORTS  = 2;

  localparam int K_RD_VAL  = 0;
  localparam int K_RD_BUSY = 1;
  localparam int K_BUSY    = 2;

  localparam int D_BYP = 0;
  localparam int D_NOB = 1;

  typedef struct {
    int          cyc;
    int          kind;
    int          dut;
    int          idx;
    logic [63:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  tachyon_regfile_mp_if #(.SIZE(SIZE), .REG_WIDTH(REG_WIDTH),
                          .RD_PORTS(RD_PORTS), .WR_PORTS(WR_PORTS)) bus_byp ();
  tachyon_regfile_mp_if #(.SIZE(SIZE), .REG_WIDTH(REG_WIDTH),
                          .RD_PORTS(RD_PORTS), .WR_PORTS(WR_PORTS)) bus_nob ();

  tachyon_regfile_mp #(.SIZE(SIZE), .REG_WIDTH(REG_WIDTH), .RD_PORTS(RD_PORTS),
                       .WR_PORTS(WR_PORTS), .ZERO_REG(1), .BYPASS(1))
    dut_byp (.clk(clk), .rst(rst), .bus(bus_byp));

  tachyon_regfile_mp #(.SIZE(SIZE), .REG_WIDTH(REG_WIDTH), .RD_PORTS(RD_PORTS),
                       .WR_PORTS(WR_PORTS), .ZERO_REG(1), .BYPASS(0))
    dut_nob (.clk(clk), .rst(rst), .bus(bus_nob));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] get_actual(input int kind, input int dut, input int idx);
    logic [63:0] v;
    v = '0;
    case (kind)
      K_RD_VAL:  v = (dut == D_BYP) ? bus_byp.rd_val[idx] : bus_nob.rd_val[idx];
      K_RD_BUSY: v = {63'd0, (dut == D_BYP) ? bus_byp.rd_busy[idx] : bus_nob.rd_busy[idx]};
      default:   v = {32'd0, (dut == D_BYP) ? bus_byp.busy : bus_nob.busy};
    endcase
    return v;
  endfunction

  task automatic check_output(input exp_t e);
    logic [63:0] act;
    act = get_actual(e.kind, e.dut, e.idx);
    checks++;
    if (act !== e.val) begin
      errors++;
      $display("[TB] FAIL %s (%s) cycle %0d: got %h expected %h",
               e.name, (e.dut == D_BYP) ? "byp" : "nob", e.cyc, act, e.val);
    end
  endtask

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].cyc <= cyc) begin
        if (exp_q[i].cyc < cyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL stale_%s expected at cycle %0d, now %0d", exp_q[i].name, exp_q[i].cyc, cyc);
        end else begin
          check_output(exp_q[i]);
        end
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic push_exp(input int kind, input int dut, input int idx,
                          input logic [63:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.dut  = dut;
    e.idx  = idx;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic push_both(input int kind, input int idx, input logic [63:0] val, input string name);
    push_exp(kind, D_BYP, idx, val, name);
    push_exp(kind, D_NOB, idx, val, name);
  endtask

  task automatic drive_bus(input logic we0, input logic [4:0] wa0, input logic [63:0] wv0,
                           input logic we1, input logic [4:0] wa1, input logic [63:0] wv1,
                           input logic sb_en, input logic [4:0] sb_a,
                           input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2);
    bus_byp.wr_enable[0] = we0; bus_nob.wr_enable[0] = we0;
    bus_byp.wr_addr[0]   = wa0; bus_nob.wr_addr[0]   = wa0;
    bus_byp.wr_val[0]    = wv0; bus_nob.wr_val[0]    = wv0;
    bus_byp.wr_enable[1] = we1; bus_nob.wr_enable[1] = we1;
    bus_byp.wr_addr[1]   = wa1; bus_nob.wr_addr[1]   = wa1;
    bus_byp.wr_val[1]    = wv1; bus_nob.wr_val[1]    = wv1;
    bus_byp.sb_set_en    = sb_en; bus_nob.sb_set_en   = sb_en;
    bus_byp.sb_set_addr  = sb_a;  bus_nob.sb_set_addr = sb_a;
    bus_byp.rd_addr[0]   = ra0; bus_nob.rd_addr[0]   = ra0;
    bus_byp.rd_addr[1]   = ra1; bus_nob.rd_addr[1]   = ra1;
    bus_byp.rd_addr[2]   = ra2; bus_nob.rd_addr[2]   = ra2;
  endtask

  // One cycle of stimulus, applied shortly after the rising edge.
  task automatic apply_stimulus(input logic r,
                                input logic we0, input logic [4:0] wa0, input logic [63:0] wv0,
                                input logic we1, input logic [4:0] wa1, input logic [63:0] wv1,
                                input logic sb_en, input logic [4:0] sb_a,
                                input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ra2);
    @(posedge clk);
    #1;
    rst = r;
    drive_bus(we0, wa0, wv0, we1, wa1, wv1, sb_en, sb_a, ra0, ra1, ra2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive_bus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);

    // Reset then read 0, 17, 31.
    apply_stimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd17, 5'd31);
    for (int j = 0; j < RD_PORTS; j++) begin
      push_both(K_RD_VAL, j, 64'd0, "reset_rd_val");
      push_both(K_RD_BUSY, j, 64'd0, "reset_rd_busy");
    end
    push_both(K_BUSY, 0, 64'd0, "reset_busy");

    // Basic write of addr 5: bypass visible only on dut_byp in the same cycle.
    apply_stimulus(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0, 64'd0,
                   1'b0, 5'd0, 5'd5, 5'd0, 5'd0);
    push_exp(K_RD_VAL, D_BYP, 0, 64'hDEAD_BEEF_0000_0001, "wr5_same_cycle");
    push_exp(K_RD_VAL, D_NOB, 0, 64'd0, "wr5_same_cycle");
    apply_stimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0);
    push_both(K_RD_VAL, 0, 64'hDEAD_BEEF_0000_0001, "wr5_next_cycle");

    // Collision on addr 9: port 1 wins; all read ports alias 9.
    apply_stimulus(1'b0, 1'b1, 5'd9, 64'h11, 1'b1, 5'd9, 64'h22, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9);
    for (int j = 0; j < RD_PORTS; j++) begin
      push_exp(K_RD_VAL, D_BYP, j, 64'h22, "collide_bypass");
      push_exp(K_RD_VAL, D_NOB, j, 64'h0, "collide_bypass");
    end
    apply_stimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd9, 5'd5, 5'd0);
    push_both(K_RD_VAL, 0, 64'h22, "collide_stored");
    push_both(K_RD_VAL, 1, 64'hDEAD_BEEF_0000_0001, "addr5_kept");

    // Zero register: write 0xFF to addr 0 and set busy on it.
    apply_stimulus(1'b0, 1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
    push_both(K_RD_VAL, 0, 64'd0, "zero_same_cycle");
    push_both(K_RD_BUSY, 0, 64'd0, "zero_rd_busy_same");
    apply_stimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    push_both(K_RD_VAL, 0, 64'd0, "zero_next_cycle");
    push_both(K_RD_BUSY, 0, 64'd0, "zero_rd_busy_next");
    push_both(K_BUSY, 0, 64'd0, "zero_busy_vec");

    // Scoreboard on register 12, read on port 2.
    apply_stimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd12, 5'd0, 5'd0, 5'd12);
    push_both(K_RD_BUSY, 2, 64'd0, "sb_before_set");
    push_both(K_BUSY, 0, 64'd0, "sb_vec_before_set");
    apply_stimulus(1'b0, 1'b1, 5'd12, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b1, 5'd12, 5'd0, 5'd0, 5'd12);
    push_both(K_RD_BUSY, 2, 64'd1, "sb_after_set");
    push_both(K_BUSY, 0, 64'h1000, "sb_vec_after_set");
    apply_stimulus(1'b0, 1'b1, 5'd12, 64'h5678, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd12);
    push_both(K_RD_BUSY, 2, 64'd1, "sb_set_beats_clear");
    push_both(K_BUSY, 0, 64'h1000, "sb_vec_set_beats_clear");
    push_exp(K_RD_VAL, D_BYP, 2, 64'h5678, "r12_bypass");
    push_exp(K_RD_VAL, D_NOB, 2, 64'h1234, "r12_bypass");
    apply_stimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd12);
    push_both(K_RD_BUSY, 2, 64'd0, "sb_cleared");
    push_both(K_BUSY, 0, 64'd0, "sb_vec_cleared");
    push_both(K_RD_VAL, 2, 64'h5678, "r12_stored");

    // Reset mid-operation.
    apply_stimulus(1'b0, 1'b1, 5'd3, 64'h7, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd3, 5'd4, 5'd0);
    push_exp(K_RD_VAL, D_BYP, 0, 64'h7, "pre_reset_wr3");
    push_exp(K_RD_VAL, D_NOB, 0, 64'h0, "pre_reset_wr3");
    apply_stimulus(1'b1, 1'b1, 5'd4, 64'h9, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 5'd3, 5'd4, 5'd7);
    push_both(K_RD_VAL, 0, 64'h7, "pre_reset_r3_stored");
    push_exp(K_RD_VAL, D_NOB, 1, 64'h0, "pre_reset_r4");
    push_both(K_BUSY, 0, 64'h80, "pre_reset_busy");
    apply_stimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd4, 5'd7);
    push_both(K_RD_VAL, 0, 64'h0, "post_reset_r3");
    push_both(K_RD_VAL, 1, 64'h0, "post_reset_r4");
    push_both(K_RD_BUSY, 2, 64'h0, "post_reset_rd_busy7");
    push_both(K_BUSY, 0, 64'h0, "post_reset_busy");

    apply_stimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drained: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
